// File: rtl/divmod_seq.sv
// divmod_seq -- multi-cycle restoring divider returning quotient and remainder.
//
// One quotient bit is produced per clock, so latency is WIDTH+1 cycles from an
// accepted start to the done pulse regardless of operand values. A zero divisor
// short-circuits to DONE one cycle after acceptance.
//
// Handshake: start is sampled only while the FSM is IDLE; a start seen in IDLE
// is accepted on that clock edge and the operands a/b are captured then. start
// in any other state is ignored (no queuing). done pulses for exactly one cycle
// and the result outputs are valid from that cycle until the next done.
//
// Optional feature macro: DIVMOD_SIGNED_EN -- when defined, a and b are two's
// complement; quotient truncates toward zero and remainder takes the sign of
// the dividend. When undefined the unit is purely unsigned.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high; drops any operation in progress
//   start        operation request
//   a, b         dividend / divisor (WIDTH bits)
//   busy         high while an operation is in flight (CALC or DONE)
//   done         one-cycle completion pulse
//   quotient     a / b      (all ones when b == 0)
//   remainder    a % b      (a when b == 0)
//   div_by_zero  set with done when b was 0, held with the results
//   fsm_state    debug view of the FSM state (0 IDLE, 1 CALC, 2 DONE)

module divmod_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]    count;
    // The partial remainder is always < D after each step, so its top bit is
    // always zero; only the low WIDTH bits are kept. The trial value T below
    // carries the full WIDTH+1 bits for the comparison.
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = (b == '0) ? S_DONE : S_CALC;
            S_CALC: if (count == '0) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (state-decoded only) ----------------
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        fsm_state = state;
    end

    // ---------------- one restoring shift-subtract step ----------------
    always_comb begin
        trial  = {rem_r, q_r[WIDTH-1]};
        fits   = (trial >= {1'b0, d_r});
        // When fits, trial - D < D fits in WIDTH bits, so the low-bit subtract
        // is exact.
        r_next = fits ? (trial[WIDTH-1:0] - d_r) : trial[WIDTH-1:0];
        q_next = {q_r[WIDTH-2:0], fits};
    end

`ifdef DIVMOD_SIGNED_EN
    logic sq_r;
    logic sr_r;

    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            d_r         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVMOD_SIGNED_EN
            sq_r        <= 1'b0;
            sr_r        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d_r   <= b_mag;
                        q_r   <= a_mag;
                        rem_r <= '0;
                        count <= COUNT_INIT;
`ifdef DIVMOD_SIGNED_EN
                        sq_r  <= a[WIDTH-1] ^ b[WIDTH-1];
                        sr_r  <= a[WIDTH-1];
`endif
                        // Zero divisor: results are written now, the DONE
                        // cycle that follows presents them.
                        if (b == '0) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    rem_r <= r_next;
                    q_r   <= q_next;
                    if (count == '0) begin
`ifdef DIVMOD_SIGNED_EN
                        quotient  <= sq_r ? -q_next : q_next;
                        remainder <= sr_r ? -r_next : r_next;
`else
                        quotient  <= q_next;
                        remainder <= r_next;
`endif
                        div_by_zero <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
